wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 24 ++
 rtl/wb_regfile.sv | 76 +++++++
 2 files changed

// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile_pkg : shared pipeline widths and write-back helpers       |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package wb_regfile_pkg;

   localparam int DSIZE = 32;
   localparam int ASIZE = 5;
   localparam int NREGS = 1 << ASIZE;
   localparam int CSIZE = 32;

   typedef logic [DSIZE-1:0] data_t;
   typedef logic [ASIZE-1:0] addr_t;
   typedef logic [CSIZE-1:0] count_t;

   function automatic data_t wb_select(input logic  mem_to_reg,
                                       input data_t result,
                                       input data_t rdata_mem);
      return mem_to_reg ? rdata_mem : result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_regfile : 2R/1W register file with write-first bypass + wb counter |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic             mem_to_reg,
   input  logic [DSIZE-1:0] result,
   input  logic [DSIZE-1:0] rdata_mem,
   input  logic [ASIZE-1:0] waddr,
   input  logic [ASIZE-1:0] raddr1,
   input  logic [ASIZE-1:0] raddr2,
   output logic [DSIZE-1:0] rdata1,
   output logic [DSIZE-1:0] rdata2,
   output logic [DSIZE-1:0] wb_data,
   output logic [31:0]      wb_count
);

   data_t  regs [NREGS];
   logic   wr_en;
   count_t count_r;
   count_t count_next;

   assign wb_data = wb_select(mem_to_reg, result, rdata_mem);

   // Qualifying with rst_n also keeps the bypass from leaking wb_data during reset.
   assign wr_en = wen && (waddr != '0) && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[waddr] <= wb_data;
      end
   end

   always_comb begin
      rdata1 = regs[raddr1];
      if (!rst_n || (raddr1 == '0)) begin
         rdata1 = '0;
      end else if (wr_en && (raddr1 == waddr)) begin
         rdata1 = wb_data;
      end
   end

   always_comb begin
      rdata2 = regs[raddr2];
      if (!rst_n || (raddr2 == '0)) begin
         rdata2 = '0;
      end else if (wr_en && (raddr2 == waddr)) begin
         rdata2 = wb_data;
      end
   end

   // Register loaded every edge so the hold case is an explicit reload.
   assign count_next = count_r + {{(CSIZE-1){1'b0}}, wr_en};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else begin
         count_r <= count_next;
      end
   end

   assign wb_count = count_r;

endmodule
`default_nettype wire
